// File: rtl/lights_game_pkg.sv
// Shared constants for the lights game: FSM state encoding and red-light motion modes.
package lights_game_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WIN  = 2'd2;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: free-runs 0..TICK_DIV-1 while enabled, held at zero otherwise.
module tick_gen #(
  parameter int TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!enable) begin
      count_d = '0;
    end else if (count_q == COUNT_LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable && (count_q == COUNT_LAST);

endmodule

// File: rtl/lights_game_gen.sv
// Reaction game: a red light runs across the LED bank and the player scores by
// parking the green cursor where the red light lands on a tick.
module lights_game_gen
  import lights_game_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int TICK_DIV = 12500000,
  parameter int WIN_HITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           button1,
  input  logic                           button2,
  input  logic                           modo,
  output logic [N_LEDS-1:0]              leds_red,
  output logic [N_LEDS-1:0]              leds_green,
  output logic [$clog2(WIN_HITS+1)-1:0]  score
);

  localparam int PW = $clog2(N_LEDS);
  localparam int SW = $clog2(WIN_HITS + 1);
  localparam logic [PW-1:0]     POS_LAST  = PW'(N_LEDS - 1);
  localparam logic [SW-1:0]     SCORE_WIN = SW'(WIN_HITS);
  localparam logic [N_LEDS-1:0] LED_ONE   = N_LEDS'(1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] p_red_q, p_red_d;
  logic [PW-1:0] p_grn_q, p_grn_d;
  logic          dir_up_q, dir_up_d;
  logic [SW-1:0] score_q, score_d;
  logic          sync1_up_q, sync2_up_q, prev_up_q;
  logic          sync1_dn_q, sync2_dn_q, prev_dn_q;

  logic [PW-1:0] red_next;
  logic          dir_next;
  logic [SW-1:0] score_inc;
  logic          up_rise, dn_rise;
  logic          run, tick;

  assign run       = (state_q == ST_RUN);
  assign up_rise   = sync2_up_q & ~prev_up_q;
  assign dn_rise   = sync2_dn_q & ~prev_dn_q;
  assign score_inc = score_q + SW'(1);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (run),
    .tick   (tick)
  );

  // Where the red light goes on the next tick; bounce reflects off either end.
  always_comb begin
    red_next = p_red_q;
    dir_next = dir_up_q;
    if (modo == MODE_WRAP) begin
      red_next = (p_red_q == POS_LAST) ? '0 : p_red_q + PW'(1);
    end else if (dir_up_q) begin
      if (p_red_q == POS_LAST) begin
        red_next = POS_LAST - PW'(1);
        dir_next = 1'b0;
      end else begin
        red_next = p_red_q + PW'(1);
      end
    end else begin
      if (p_red_q == '0) begin
        red_next = PW'(1);
        dir_next = 1'b1;
      end else begin
        red_next = p_red_q - PW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    p_red_d  = p_red_q;
    dir_up_d = dir_up_q;
    score_d  = score_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_RUN;
          p_red_d  = '0;
          dir_up_d = 1'b1;
          score_d  = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          p_red_d  = red_next;
          dir_up_d = dir_next;
          // A hit compares against the cursor as it stood before this edge.
          if ((red_next == p_grn_q) && (score_q != SCORE_WIN)) begin
            score_d = score_inc;
            if (score_inc == SCORE_WIN) begin
              state_d = ST_WIN;
            end
          end
        end
      end
      ST_WIN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Simultaneous presses cancel; the cursor is frozen once the game is won.
  always_comb begin
    p_grn_d = p_grn_q;
    if (state_q != ST_WIN) begin
      if (up_rise && !dn_rise && (p_grn_q != POS_LAST)) begin
        p_grn_d = p_grn_q + PW'(1);
      end else if (dn_rise && !up_rise && (p_grn_q != '0)) begin
        p_grn_d = p_grn_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      p_red_q    <= '0;
      dir_up_q   <= 1'b1;
      p_grn_q    <= POS_LAST;
      score_q    <= '0;
      sync1_up_q <= 1'b0;
      sync2_up_q <= 1'b0;
      prev_up_q  <= 1'b0;
      sync1_dn_q <= 1'b0;
      sync2_dn_q <= 1'b0;
      prev_dn_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_red_q    <= p_red_d;
      dir_up_q   <= dir_up_d;
      p_grn_q    <= p_grn_d;
      score_q    <= score_d;
      sync1_up_q <= button1;
      sync2_up_q <= sync1_up_q;
      prev_up_q  <= sync2_up_q;
      sync1_dn_q <= button2;
      sync2_dn_q <= sync1_dn_q;
      prev_dn_q  <= sync2_dn_q;
    end
  end

  assign leds_red   = run ? (LED_ONE << p_red_q) : '0;
  assign leds_green = (state_q == ST_WIN) ? '1 : (LED_ONE << p_grn_q);
  assign score      = score_q;

endmodule

// File: tb/tb_lights_game_gen.sv
// Scoreboard bench for lights_game_gen at N_LEDS=8, TICK_DIV=4, WIN_HITS=2.
module tb_lights_game_gen;

  localparam int N_LEDS   = 8;
  localparam int TICK_DIV = 4;
  localparam int WIN_HITS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       button1;
  logic       button2;
  logic       modo;
  logic [7:0] leds_red;
  logic [7:0] leds_green;
  logic [1:0] score;

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    string      tag;
    logic [7:0] red;
    logic [7:0] grn;
    logic [1:0] score;
  } expEntry_t;

  expEntry_t expQ[$];

  always #5 clk = ~clk;

  lights_game_gen #(
    .N_LEDS   (N_LEDS),
    .TICK_DIV (TICK_DIV),
    .WIN_HITS (WIN_HITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .button1    (button1),
    .button2    (button2),
    .modo       (modo),
    .leds_red   (leds_red),
    .leds_green (leds_green),
    .score      (score)
  );

  function automatic logic [7:0] oneHot(input int pos);
    logic [7:0] v;
    v = 8'd1;
    return v << pos;
  endfunction

  // Red position after k edges in bounce mode: 0..7 then 6..1, period 14 ticks.
  function automatic int bouncePos(input int k);
    int i;
    i = (k / TICK_DIV) % 14;
    return (i <= 7) ? i : 14 - i;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkScoreboard();
    expEntry_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.tag, ".red"},   32'(leds_red),   32'(e.red));
      checkOutput({e.tag, ".grn"},   32'(leds_green), 32'(e.grn));
      checkOutput({e.tag, ".score"}, 32'(score),      32'(e.score));
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the next edge, then compare.
  task automatic applyStimulus(input string tag, input logic rst, input logic en, input logic b1,
                               input logic b2, input logic md, input logic [7:0] eRed,
                               input logic [7:0] eGrn, input logic [1:0] eScore);
    expEntry_t e;
    reset   = rst;
    enable  = en;
    button1 = b1;
    button2 = b2;
    modo    = md;
    e.tag   = tag;
    e.red   = eRed;
    e.grn   = eGrn;
    e.score = eScore;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkScoreboard();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] g;
    logic [1:0] s;
    reset   = 1'b0;
    enable  = 1'b0;
    button1 = 1'b0;
    button2 = 1'b0;
    modo    = 1'b0;

    for (int i = 0; i < 2; i++)
      applyStimulus($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 2'd0);
    applyStimulus("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 2'd0);

    // Wrap mode with cursor at 7: hit at k=28, second hit and win at k=60.
    for (int k = 0; k < 64; k++) begin
      if (k < 60) begin
        r = oneHot((k / TICK_DIV) % N_LEDS);
        g = 8'h80;
        s = (k >= 28) ? 2'd1 : 2'd0;
      end else begin
        r = 8'h00;
        g = 8'hFF;
        s = 2'd2;
      end
      applyStimulus($sformatf("wrap%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, r, g, s);
    end
    for (int c = 0; c < 4; c++)
      applyStimulus($sformatf("winFrozenPress%0d", c), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 2'd2);
    for (int c = 0; c < 3; c++)
      applyStimulus($sformatf("winFrozenRel%0d", c), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 2'd2);
    applyStimulus("winToIdle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 2'd2);

    // Bounce mode: one hit when red first reaches 7, then back down to 0 and up to 1.
    for (int k = 0; k < 64; k++) begin
      s = (k >= 28) ? 2'd1 : 2'd0;
      applyStimulus($sformatf("bounce%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, oneHot(bouncePos(k)), 8'h80, s);
    end
    applyStimulus("bounceToIdle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h80, 2'd1);

    // Cursor moves on the third edge after a press, once per press.
    for (int c = 1; c <= 10; c++)
      applyStimulus($sformatf("btn2Hold%0d", c), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00,
                    (c >= 3) ? 8'h40 : 8'h80, 2'd1);
    for (int c = 0; c < 3; c++)
      applyStimulus($sformatf("btn2Rel%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 2'd1);
    for (int c = 0; c < 5; c++)
      applyStimulus($sformatf("btnBoth%0d", c), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 2'd1);
    for (int c = 0; c < 3; c++)
      applyStimulus($sformatf("btnBothRel%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 2'd1);
    for (int c = 1; c <= 4; c++)
      applyStimulus($sformatf("btn1Up%0d", c), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,
                    (c >= 3) ? 8'h80 : 8'h40, 2'd1);
    for (int c = 0; c < 3; c++)
      applyStimulus($sformatf("btn1Rel%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 2'd1);
    for (int c = 0; c < 5; c++)
      applyStimulus($sformatf("btn1Sat%0d", c), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 2'd1);
    for (int c = 0; c < 3; c++)
      applyStimulus($sformatf("btn1SatRel%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 2'd1);

    // Reset in the middle of a run with score 1.
    for (int k = 0; k < 30; k++) begin
      s = (k >= 28) ? 2'd1 : 2'd0;
      applyStimulus($sformatf("midRun%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    oneHot((k / TICK_DIV) % N_LEDS), 8'h80, s);
    end
    applyStimulus("midRunReset0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 2'd0);
    applyStimulus("midRunReset1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h80, 2'd0);
    applyStimulus("rerun", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 2'd0);
    applyStimulus("rerunStop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 2'd0);

    checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/lights_game_gen.md
LIGHTS_GAME_GEN -- requirements
Module: lights_game_gen

Interface
REQ-001 Parameter N_LEDS, default 8, number of LEDs per bank (>=2).
REQ-002 Parameter TICK_DIV, default 12500000, clk cycles per game tick (>=2).
REQ-003 Parameter WIN_HITS, default 4, hits needed to win (>=1).
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset.
REQ-006 Port enable  input  1  game run request; level-sensitive.
REQ-007 Port button1  input  1  asynchronous push button, cursor up (towards MSB).
REQ-008 Port button2  input  1  asynchronous push button, cursor down (towards LSB).
REQ-009 Port modo  input  1  red-light motion mode: 0 wrap, 1 bounce.
REQ-010 Port leds_red  output  N_LEDS  running light, one-hot or zero.
REQ-011 Port leds_green  output  N_LEDS  player cursor, one-hot, or all-ones on win.
REQ-012 Port score  output  clog2(WIN_HITS+1)  current hit count.

Function
REQ-013 FSM states IDLE, RUN, WIN; IDLE->RUN when enable=1; RUN->IDLE or WIN->IDLE when enable=0; RUN->WIN on the edge where score becomes WIN_HITS.
REQ-014 Entering RUN: red position p_red=0, direction up, score=0, prescaler=0; p_grn retained.
REQ-015 Prescaler counts 0..TICK_DIV-1 only in RUN, cleared otherwise; tick is asserted in the cycle where count==TICK_DIV-1; first tick TICK_DIV cycles after RUN entry.
REQ-016 On tick, modo=0: p_red increments, N_LEDS-1 wraps to 0.
REQ-017 On tick, modo=1: p_red moves in its direction; at N_LEDS-1 going up, reverses and moves to N_LEDS-2; at 0 going down, reverses and moves to 1; modo change takes effect on the next tick, direction kept.
REQ-018 Buttons pass a 2-flop synchroniser then rising-edge detect; p_grn updates on the 3rd clk edge after the button rises; one move per press regardless of hold time.
REQ-019 button1 edge: p_grn+1 saturating at N_LEDS-1; button2 edge: p_grn-1 saturating at 0; both edges in same cycle: no move; cursor moves in IDLE and RUN, frozen in WIN.
REQ-020 Hit: on a tick in RUN where new p_red equals the registered (pre-update) p_grn, score increments; score never exceeds WIN_HITS.
REQ-021 leds_red = one-hot(p_red) in RUN, zero in IDLE and WIN.
REQ-022 leds_green = one-hot(p_grn) in IDLE and RUN, all ones in WIN.
REQ-023 score holds its value in WIN; cleared on RUN entry and on reset.

Reset
REQ-024 reset=0 at a clk edge forces state IDLE, p_red=0, direction up, p_grn=N_LEDS-1, score=0, prescaler=0, synchroniser and edge flops=0, overriding all inputs.
REQ-025 After reset: leds_red=0, leds_green=one-hot(N_LEDS-1), score=0; reset mid-RUN or mid-WIN yields the same values at the next edge.

Structure
REQ-026 Package lights_game_pkg holds the state encoding (IDLE, RUN, WIN) and mode constants (MODE_WRAP=0, MODE_BOUNCE=1).
REQ-027 Prescaler is sub-module tick_gen (parameter TICK_DIV; ports clk, reset, enable, tick); all else inline.

Verification (N_LEDS=8, TICK_DIV=4, WIN_HITS=2)
REQ-028 reset=0 two cycles -> leds_red=0x00, leds_green=0x80, score=0.
REQ-029 enable=1, modo=0 -> leds_red 0x01 for 4 cycles, then 0x02, ... 0x80, then 0x01.
REQ-030 modo=1 -> leds_red 0x01,0x02,...,0x80,0x40,...,0x01,0x02, each held 4 cycles.
REQ-031 button2 held 10 cycles -> leds_green 0x80->0x40 exactly 3 edges after rise, single step; button1 and button2 rising together -> no change; button1 at 0x80 -> stays 0x80.
REQ-032 p_grn=7, modo=0, enable=1 -> score 1 when red reaches 0x80, score 2 on next pass, WIN: leds_red=0x00, leds_green=0xFF; enable=0 -> IDLE, leds_green=0x80, score=2.
REQ-033 reset=0 mid-RUN with score=1 -> next edge IDLE, all outputs at reset values.
